wb_spi_slave: RTL

WB_SPI_SLAVE -- requirements
Module: wb_spi_slave

---
 rtl/wb_spi_pkg.sv | 45 ++++
 rtl/spi_sync.sv | 33 +++
 rtl/wb_spi_slave.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_spi_pkg.sv
// Register map, STATUS/CTRL bit positions and FSM encoding shared by the
// Wishbone SPI slave and anything else that talks to its register file.
package wb_spi_pkg;

    localparam logic [2:0] ADR_DATA   = 3'd0;
    localparam logic [2:0] ADR_STATUS = 3'd1;
    localparam logic [2:0] ADR_CTRL   = 3'd2;
    localparam logic [2:0] ADR_IDLE   = 3'd3;

    localparam int STAT_RX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_OVR      = 2;
    localparam int STAT_UDR      = 3;
    localparam int STAT_BUSY     = 4;

    localparam int CTRL_IE_RX  = 0;
    localparam int CTRL_IE_TX  = 1;
    localparam int CTRL_IE_OVR = 2;

    localparam logic [7:0] IDLE_RESET = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } spi_state_t;

    function automatic logic [31:0] pack_status(
        input logic busy,
        input logic udr,
        input logic ovr,
        input logic tx_empty,
        input logic rx_full
    );
        logic [31:0] w;
        w                = '0;
        w[STAT_BUSY]     = busy;
        w[STAT_UDR]      = udr;
        w[STAT_OVR]      = ovr;
        w[STAT_TX_EMPTY] = tx_empty;
        w[STAT_RX_FULL]  = rx_full;
        return w;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// N-stage synchroniser for an asynchronous SPI pin, with single-cycle
// rise/fall pulses taken from the last two synchronised samples.
module spi_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [N-1:0] chain;
    logic         prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= {N{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < N; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[N-1];
        end
    end

    assign rise = chain[N-1] & ~prev;
    assign fall = ~chain[N-1] & prev;

endmodule

// File: rtl/wb_spi_slave.sv
// Mode-0 SPI slave with a Wishbone register file: one RX and one TX byte
// buffer, an idle fill byte for underruns and a level interrupt.
//
// state   | meaning
// S_IDLE  | chip select high, no transfer
// S_LOAD  | one cycle after CS fall; shift register takes TX byte or idle fill
// S_SHIFT | byte transfer in progress, driven by synchronised SCK edges
module wb_spi_slave
    import wb_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        irq
);

    spi_state_t state, state_next;

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_sync;

    logic       ack, access, wr, rd, tx_wr, rx_rd;
    logic [2:0] adr;

    logic [7:0] tx_buf, rx_buf, rx_shift, sreg, idle_byte, rx_byte;
    logic [2:0] bitcount, ctrl;
    logic       tx_empty, rx_full, ovr, udr, busy;
    logic       do_load, do_rise, do_fall, reload, byte_done;
    logic       unused_bits;

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk   (clk),
        .reset (reset),
        .d     (spi_sck),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .d     (spi_cs_n),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain[0] <= spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                mosi_chain[i] <= mosi_chain[i-1];
            end
        end
    end

    assign mosi_sync = mosi_chain[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_rise    = 1'b0;
        do_fall    = 1'b0;
        if (cs_rise) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (cs_fall) state_next = S_LOAD;
                S_LOAD: begin
                    do_load    = 1'b1;
                    state_next = S_SHIFT;
                end
                S_SHIFT: begin
                    do_rise = sck_rise;
                    do_fall = sck_fall;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign access    = wb_stb_i & wb_cyc_i & ~ack;
    assign wr        = access & wb_we_i;
    assign rd        = access & ~wb_we_i;
    assign adr       = wb_adr_i[4:2];
    assign tx_wr     = wr & (adr == ADR_DATA);
    assign rx_rd     = rd & (adr == ADR_DATA);
    assign busy      = (state != S_IDLE);
    assign rx_byte   = {rx_shift[6:0], mosi_sync};
    assign byte_done = do_rise & (bitcount == 3'd7);
    // bitcount has wrapped to 0 only on the falling edge that closes a byte
    assign reload    = do_load | (do_fall & (bitcount == 3'd0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack       <= 1'b0;
            wb_dat_o  <= '0;
            tx_buf    <= '0;
            rx_buf    <= '0;
            rx_shift  <= '0;
            sreg      <= '0;
            bitcount  <= '0;
            idle_byte <= IDLE_RESET;
            ctrl      <= '0;
            tx_empty  <= 1'b1;
            rx_full   <= 1'b0;
            ovr       <= 1'b0;
            udr       <= 1'b0;
        end else begin
            ack <= wb_stb_i & wb_cyc_i;

            if (rd) begin
                case (adr)
                    ADR_DATA:   wb_dat_o <= {24'd0, rx_buf};
                    ADR_STATUS: wb_dat_o <= pack_status(busy, udr, ovr, tx_empty, rx_full);
                    ADR_CTRL:   wb_dat_o <= {29'd0, ctrl};
                    ADR_IDLE:   wb_dat_o <= {24'd0, idle_byte};
                    default:    wb_dat_o <= '0;
                endcase
            end

            if (wr) begin
                case (adr)
                    ADR_DATA: begin
                        tx_buf   <= wb_dat_i[7:0];
                        tx_empty <= 1'b0;
                    end
                    ADR_STATUS: begin
                        if (wb_dat_i[STAT_UDR]) udr <= 1'b0;
                        if (wb_dat_i[STAT_OVR]) ovr <= 1'b0;
                    end
                    ADR_CTRL: ctrl      <= wb_dat_i[2:0];
                    ADR_IDLE: idle_byte <= wb_dat_i[7:0];
                    default: ;
                endcase
            end

            if (rx_rd) rx_full <= 1'b0;

            if (cs_rise) begin
                bitcount <= '0;
                rx_shift <= '0;
            end

            if (do_rise) begin
                rx_shift <= rx_byte;
                bitcount <= bitcount + 3'd1;
            end

            // A read landing on completion gets the old byte and keeps rx_full set
            if (byte_done) begin
                rx_buf  <= rx_byte;
                rx_full <= 1'b1;
                if (rx_full && !rx_rd) ovr <= 1'b1;
            end

            if (do_fall && bitcount != 3'd0) sreg <= {sreg[6:0], 1'b0};

            if (reload) begin
                if (tx_wr) begin
                    sreg     <= wb_dat_i[7:0];
                    tx_empty <= 1'b1;
                end else if (!tx_empty) begin
                    sreg     <= tx_buf;
                    tx_empty <= 1'b1;
                end else begin
                    sreg <= idle_byte;
                    udr  <= 1'b1;
                end
            end
        end
    end

    assign wb_ack_o = wb_stb_i & wb_cyc_i & ack;
    assign spi_miso = busy & ~spi_cs_n & sreg[7];
    assign irq      = (rx_full & ctrl[CTRL_IE_RX]) | (tx_empty & ctrl[CTRL_IE_TX]) |
                      (ovr & ctrl[CTRL_IE_OVR]);

    assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i};

endmodule
